// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 init sequencer: FSM encoding, soft-reset
// register identity and init-table entry layout.
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_FETCH0,
        S_FETCH1,
        S_REQ,
        S_WAIT_DONE,
        S_RST_WAIT,
        S_NEXT,
        S_DONE,
        S_ERROR
    } seq_state_t;

    localparam int          ENTRY_W        = 24;
    localparam int          ENT_ADDR_HI    = 23;
    localparam int          ENT_ADDR_LO    = 8;
    localparam int          ENT_DATA_HI    = 7;
    localparam int          ENT_DATA_LO    = 0;
    localparam logic [15:0] SOFT_RESET_REG = 16'h3008;
    localparam int          SOFT_RESET_BIT = 7;

    function automatic logic [15:0] entry_addr(input logic [ENTRY_W-1:0] e);
        return e[ENT_ADDR_HI:ENT_ADDR_LO];
    endfunction

    function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[ENT_DATA_HI:ENT_DATA_LO];
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/init_delay_timer.sv
// Load / count-down / expire counter shared by the power-up and soft-reset waits.
module init_delay_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loading N-1 makes the wait state last exactly N cycles.
    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init table ROM, issuing one SCCB write per entry with
// power-up / soft-reset waits and bounded NACK retries.
module ov5640_init_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int TABLE_SIZE    = 252,
    parameter int ADDR_WIDTH    = 8,
    parameter int POWERUP_DELAY = 1_000_000,
    parameter int RESET_DELAY   = 250_000,
    parameter int MAX_RETRY     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]    rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_ack,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  busy,
    output logic                  init_done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_index
);

    localparam int DLY_MAX = max2(POWERUP_DELAY, RESET_DELAY);
    localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]      PWR_LOAD = CNT_W'((POWERUP_DELAY > 0) ? POWERUP_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0]      RST_LOAD = CNT_W'((RESET_DELAY > 0) ? RESET_DELAY - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TABLE_SIZE - 1);
    localparam logic [RTY_W-1:0]      RTY_MAX  = RTY_W'(MAX_RETRY);

    seq_state_t             r_state, w_state_n;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic [RTY_W-1:0]       r_retry;
    logic                   r_wr_req, r_busy, r_init_done, r_error;
    logic [15:0]            r_wr_reg_addr;
    logic [7:0]             r_wr_data;
    logic [ADDR_WIDTH-1:0]  r_err_index;

    logic                   w_tmr_load, w_tmr_exp;
    logic [CNT_W-1:0]       w_tmr_val;
    logic                   w_start_ok, w_capture, w_idx_inc;
    logic                   w_retry_inc, w_retry_clr, w_set_err;
    logic                   w_is_soft_rst;

    init_delay_timer #(.WIDTH(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_val),
        .o_expired (w_tmr_exp)
    );

    assign w_is_soft_rst = (r_wr_reg_addr == SOFT_RESET_REG) && r_wr_data[SOFT_RESET_BIT];

    always_comb begin
        w_state_n   = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = PWR_LOAD;
        w_start_ok  = 1'b0;
        w_capture   = 1'b0;
        w_idx_inc   = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_n  = S_PWR_WAIT;
                    w_tmr_load = 1'b1;
                    w_start_ok = 1'b1;
                end
            end
            S_PWR_WAIT: if (w_tmr_exp) w_state_n = S_FETCH0;
            S_FETCH0:   w_state_n = S_FETCH1;
            S_FETCH1: begin
                w_capture = 1'b1;
                w_state_n = S_REQ;
            end
            S_REQ: if (wr_ack) w_state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A NACK outranks a coincident done; retries reuse the captured entry.
                if (wr_nack) begin
                    if (r_retry < RTY_MAX) begin
                        w_retry_inc = 1'b1;
                        w_state_n   = S_REQ;
                    end else begin
                        w_set_err = 1'b1;
                        w_state_n = S_ERROR;
                    end
                end else if (wr_done) begin
                    w_retry_clr = 1'b1;
                    if (w_is_soft_rst) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = RST_LOAD;
                        w_state_n  = S_RST_WAIT;
                    end else begin
                        w_state_n = S_NEXT;
                    end
                end
            end
            S_RST_WAIT: if (w_tmr_exp) w_state_n = S_NEXT;
            S_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_n = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                    w_state_n = S_FETCH0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_retry       <= '0;
            r_wr_req      <= 1'b0;
            r_busy        <= 1'b0;
            r_init_done   <= 1'b0;
            r_error       <= 1'b0;
            r_wr_reg_addr <= '0;
            r_wr_data     <= '0;
            r_err_index   <= '0;
        end else begin
            r_state     <= w_state_n;
            // Status outputs are decoded from the next state so they stay registered.
            r_wr_req    <= (w_state_n == S_REQ);
            r_busy      <= !(w_state_n inside {S_IDLE, S_DONE, S_ERROR});
            r_init_done <= (w_state_n == S_DONE);
            r_error     <= (w_state_n == S_ERROR);
            if (w_start_ok) begin
                r_idx   <= '0;
                r_retry <= '0;
            end
            if (w_idx_inc)   r_idx   <= r_idx + 1'b1;
            if (w_retry_inc) r_retry <= r_retry + 1'b1;
            if (w_retry_clr) r_retry <= '0;
            if (w_capture) begin
                r_wr_reg_addr <= entry_addr(rom_q);
                r_wr_data     <= entry_data(rom_q);
            end
            if (w_set_err) r_err_index <= r_idx;
        end
    end

    assign rom_addr    = r_idx;
    assign wr_req      = r_wr_req;
    assign wr_reg_addr = r_wr_reg_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign init_done   = r_init_done;
    assign error       = r_error;
    assign err_index   = r_err_index;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Scoreboard bench: scenarios push expected writes (data + cycle after start),
// a monitor pops and compares on every rising wr_req.
module tb_ov5640_init_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q = '0;
    logic        wr_req;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;
    logic        wr_ack = 1'b0;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy, init_done, error;
    logic [7:0]  err_index;

    ov5640_init_sequencer #(
        .TABLE_SIZE(4), .ADDR_WIDTH(8), .POWERUP_DELAY(10),
        .RESET_DELAY(20), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
        .wr_req(wr_req), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy),
        .init_done(init_done), .error(error), .err_index(err_index)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          at;
    } wr_t;

    wr_t         exp_q[$];
    int          resp_q[$];   // 0 = done, 1 = nack only, 2 = done+nack
    logic [23:0] rom [0:3];
    int          cyc = 0;
    int          t0 = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: address sampled at the edge, data one clock later.
    initial begin : rom_model
        logic [7:0] a;
        rom[0] = 24'h3103_11; rom[1] = 24'h3008_82;
        rom[2] = 24'h3008_42; rom[3] = 24'h4740_20;
        forever begin
            @(posedge clk);
            a = rom_addr;
            #1 rom_q = (a < 8'd4) ? rom[a[1:0]] : 24'hDEAD00;
        end
    end

    // SCCB master: ack one cycle after wr_req, done five cycles after ack.
    initial begin : sccb_model
        int cnt;
        int r;
        bit act;
        act = 0; cnt = 0;
        forever begin
            @(negedge clk);
            wr_ack = 0; wr_done = 0; wr_nack = 0;
            if (rst) begin
                act = 0;
            end else if (!act) begin
                if (wr_req) begin act = 1; cnt = 0; end
            end else begin
                cnt++;
                if (cnt == 1) wr_ack = 1;
                if (cnt == 6) begin
                    r = 0;
                    if (resp_q.size() != 0) r = resp_q.pop_front();
                    wr_done = (r != 1);
                    wr_nack = (r != 0);
                    act = 0;
                end
            end
        end
    end

    initial begin : monitor
        logic prev;
        wr_t  e;
        int   now;
        prev = 0;
        forever begin
            @(negedge clk);
            if (wr_req && !prev) begin
                now = cyc - t0 + 1;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write got %h_%h at cycle %0d, none expected",
                             wr_reg_addr, wr_data, now);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_reg_addr !== e.addr || wr_data !== e.data || now != e.at) begin
                        n_err++;
                        $display("FAIL write got %h_%h @%0d, required %h_%h @%0d",
                                 wr_reg_addr, wr_data, now, e.addr, e.data, e.at);
                    end
                end
            end
            prev = wr_req;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic expect_wr(input logic [23:0] ent, input int at);
        wr_t w;
        w.addr = ent[23:8];
        w.data = ent[7:0];
        w.at   = at;
        exp_q.push_back(w);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 t0 = cyc;
        start = 0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (busy) begin
            n_err++;
            $display("FAIL %s_timeout busy=1 after %0d cycles, required 0", tag, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_req"}, wr_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_wr_reg_addr"}, wr_reg_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_index"}, err_index, 0);
    endtask

    task automatic clean_run(input string tag);
        expect_wr(24'h3103_11, 13);
        expect_wr(24'h3008_82, 23);
        expect_wr(24'h3008_42, 53);   // 20-cycle soft-reset wait + 4
        expect_wr(24'h4740_20, 63);
        do_start();
        check({tag, "_busy_c1"}, busy, 1);
        check({tag, "_error_clr"}, error, 0);
        check({tag, "_done_clr"}, init_done, 0);
        wait_idle(200, tag);
        check({tag, "_init_done"}, init_done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 0;
        repeat (3) @(negedge clk);

        clean_run("clean");

        // Entry 2 NACKed twice; also a stray start mid-run must be ignored.
        resp_q = '{0, 0, 1, 1, 0, 0};
        expect_wr(24'h3103_11, 13);
        expect_wr(24'h3008_82, 23);
        expect_wr(24'h3008_42, 53);
        expect_wr(24'h3008_42, 60);
        expect_wr(24'h3008_42, 67);
        expect_wr(24'h4740_20, 77);
        do_start();
        repeat (30) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle(200, "retry");
        check("retry_init_done", init_done, 1);
        check("retry_error", error, 0);
        check("retry_writes_left", exp_q.size(), 0);

        // Entry 3 NACKed three times: retries exhausted.
        resp_q = '{0, 0, 0, 1, 1, 1};
        expect_wr(24'h3103_11, 13);
        expect_wr(24'h3008_82, 23);
        expect_wr(24'h3008_42, 53);
        expect_wr(24'h4740_20, 63);
        expect_wr(24'h4740_20, 70);
        expect_wr(24'h4740_20, 77);
        do_start();
        wait_idle(200, "exhaust");
        check("exhaust_error", error, 1);
        check("exhaust_err_index", err_index, 3);
        check("exhaust_busy", busy, 0);
        check("exhaust_init_done", init_done, 0);
        repeat (30) @(negedge clk);
        check("exhaust_writes_left", exp_q.size(), 0);
        check("exhaust_no_req", wr_req, 0);

        clean_run("rerun");

        // Coincident done+nack on entry 0 counts as a retry.
        resp_q = '{2, 0, 0, 0, 0};
        expect_wr(24'h3103_11, 13);
        expect_wr(24'h3103_11, 20);
        expect_wr(24'h3008_82, 30);
        expect_wr(24'h3008_42, 60);
        expect_wr(24'h4740_20, 70);
        do_start();
        wait_idle(200, "coinc");
        check("coinc_init_done", init_done, 1);
        check("coinc_writes_left", exp_q.size(), 0);
        resp_q.delete();

        // Asynchronous reset while wr_req is high.
        expect_wr(24'h3103_11, 13);
        do_start();
        repeat (13) @(negedge clk);
        check("midrst_req_before", wr_req, 1);
        #2 rst = 1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        #2 rst = 0;
        check("midrst_writes_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        clean_run("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ov5640_init_sequencer.md
# ov5640_init_sequencer

Walks the OV5640 init register table (synchronous ROM, 24-bit entries `{reg_addr[15:0], data[7:0]}`) and issues one SCCB register write per entry. It sits between the init table ROM and the SCCB write master. It inserts the power-up and post-soft-reset waits the sensor requires, retries NACKed writes, and reports completion or failure to the camera top level.

## Interface
Parameters:
- `TABLE_SIZE`, 252: number of valid ROM entries, indices 0..TABLE_SIZE-1.
- `ADDR_WIDTH`, 8: ROM address width.
- `POWERUP_DELAY`, 1_000_000: clk cycles to wait after `start` before entry 0 (20 ms @ 50 MHz).
- `RESET_DELAY`, 250_000: clk cycles to wait after a soft-reset write completes (5 ms @ 50 MHz).
- `MAX_RETRY`, 3: extra attempts per entry after a NACK before declaring error.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; the ROM shares it.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins the sequence.
- `rom_addr` out ADDR_WIDTH: registered ROM index.
- `rom_q` in 24: ROM data, valid one clk after `rom_addr` changes.
- `wr_req` out 1: write request to the SCCB master.
- `wr_reg_addr` out 16: register address, stable while `wr_req` is high.
- `wr_data` out 8: register data, stable while `wr_req` is high.
- `wr_ack` in 1: master accepted the request (single-cycle).
- `wr_done` in 1: transaction finished (single-cycle).
- `wr_nack` in 1: transaction failed with no slave ACK (single-cycle, may coincide with `wr_done`).
- `busy` out 1: high from `start` acceptance until DONE or ERROR.
- `init_done` out 1: level; whole table written successfully.
- `error` out 1: level; an entry exhausted its retries.
- `err_index` out ADDR_WIDTH: index of the failing entry.

## Operation
- States:
  - IDLE
  - PWR_WAIT
  - FETCH0: ROM samples the address.
  - FETCH1: capture `rom_q` into `wr_reg_addr`/`wr_data`.
  - REQ
  - WAIT_DONE
  - RST_WAIT
  - NEXT
  - DONE
  - ERROR
- IDLE/DONE/ERROR accept `start`:
  - Clear index, retry count, `init_done`, `error`.
  - Set `busy`, go to PWR_WAIT.
- `start` in any other state is ignored.
- PWR_WAIT: count POWERUP_DELAY cycles, then FETCH0.
- FETCH0 → FETCH1 → REQ.
- REQ: `wr_req` high. It drops on the cycle after `wr_ack` is sampled; state goes to WAIT_DONE.
- WAIT_DONE:
  - `wr_nack` (alone or together with `wr_done`) = failure. NACK wins.
    - If retry count < MAX_RETRY: increment it, return to REQ with the same captured data. No ROM refetch.
    - Otherwise go to ERROR with `err_index` = index.
  - `wr_done` without `wr_nack` = success. Clear retry count.
    - If the captured entry has `reg_addr == 16'h3008` and `data[7] == 1`: go to RST_WAIT.
    - Otherwise go to NEXT.
- RST_WAIT: count RESET_DELAY cycles, then NEXT.
- NEXT:
  - If index == TABLE_SIZE-1: go to DONE (`init_done`=1, `busy`=0).
  - Otherwise increment index and go to FETCH0.
- ERROR: `error`=1, `busy`=0. Hold until `start` or `rst`.
- `wr_ack`/`wr_done`/`wr_nack` outside REQ/WAIT_DONE are ignored.
- The index never wraps. TABLE_SIZE=1 is legal; TABLE_SIZE > 2**ADDR_WIDTH is illegal.

## Timing
- Reset values:
  - `rom_addr`=0, `wr_req`=0, `wr_reg_addr`=0, `wr_data`=0.
  - `busy`=0, `init_done`=0, `error`=0, `err_index`=0.
  - state IDLE.
- `rst` asserted mid-transaction drops `wr_req` immediately (asynchronously) and abandons the sequence. There is no resume.
- `start` at cycle 0 → `busy` at cycle 1 → first `wr_req` at cycle POWERUP_DELAY+3.
- Entry-to-entry overhead with no delay and no retry: 4 cycles (NEXT, FETCH0, FETCH1, REQ) from `wr_done` to the next `wr_req`.
- A retry reasserts `wr_req` 1 cycle after `wr_nack`.
- All outputs are registered. No combinational input→output paths.

## Structure
- Shared package `ov5640_cfg_pkg` holds:
  - State encoding.
  - `SOFT_RESET_REG` = 16'h3008 and soft-reset bit position 7.
  - Entry field slices (addr [23:8], data [7:0]).
- One sub-module, `init_delay_timer`: a load/count-down/expire counter wide enough for max(POWERUP_DELAY, RESET_DELAY). PWR_WAIT and RST_WAIT both use it.
- The ROM and the SCCB master are external.

## Test plan
Common bench setup: TABLE_SIZE=4, POWERUP_DELAY=10, RESET_DELAY=20, MAX_RETRY=2, ROM = {3103_11, 3008_82, 3008_42, 4740_20}. The SCCB model acks 1 cycle after `wr_req` and signals done 5 cycles after ack.

- Clean run: `start` → exactly 4 writes in ROM order, first `wr_req` at cycle 13. `init_done`=1, `busy`=0 at end.
- Soft-reset wait: the gap from the `wr_done` of 3008_82 to the `wr_req` of 3008_42 is 20+4 cycles. Every other entry-to-entry gap is 4.
- NACK retried: entry 2 NACKed twice then succeeds → 3 identical writes of 3008_42, no ROM refetch, `init_done`=1.
- NACK exhausted: entry 3 NACKed 3 times → `error`=1, `err_index`=3, `busy`=0, no further `wr_req`. A new `start` reruns from entry 0.
- Coincident `wr_done`+`wr_nack` on entry 0 → treated as a retry, not a success.
- `rst` pulse while `wr_req` is high → all outputs return to reset values within the same cycle. `start` after reset reruns cleanly.
